psum_acc_spad: RTL and testbench

- Parametrised successor of the partial-sum scratchpad inside the PE.
- Width and depth are generic; `DEPTH` is a power of two.
- Adds an in-place accumulate mode: a read-modify-write pipeline with hazard forwarding.
- Adds a registered read port and a multi-cycle clear sequencer, so a psum tile can be zeroed without a global reset.

---
 rtl/psum_acc_spad.sv | 182 ++++++++++++++++++
 tb/tb_psum_acc_spad.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_spad.sv
// Partial-sum scratchpad: 2-stage accumulate pipeline with forwarding, registered
// read port and clear sequencer. Define PSUM_SAT_EN for saturating accumulate.
module psum_acc_spad #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic              acc_mode,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr_start,
    output logic              busy,
    output logic              ovf_flag
);

    // state    | meaning
    // ST_IDLE  | accepting requests, waiting for clr_start
    // ST_DRAIN | requests blocked, letting the pipeline empty
    // ST_CLEAR | zeroing one entry per cycle, clr_cnt_q = 0 .. DEPTH-1
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [DATA_W-1:0] rf_q [DEPTH];

    logic              va_q;
    logic              mode_a_q;
    logic [ADDR_W-1:0] addr_a_q;
    logic [DATA_W-1:0] data_a_q;
    logic              vb_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] res_b_q, res_b_d;
    logic [DATA_W-1:0] old_a;
    logic              accept;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    assign accept = acc_valid & acc_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        acc_ready = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                acc_ready = rst;
                if (clr_start) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!va_q && !vb_q) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_ADDR) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Forward the result still waiting in stage B so back-to-back updates chain.
    assign old_a = (vb_q && (addr_b_q == addr_a_q)) ? res_b_q : rf_q[addr_a_q];

`ifdef PSUM_SAT_EN
    logic [DATA_W:0] sum_a;
    logic            ovf_a;
    logic            ovf_b_q;
    logic            ovf_q;
    logic            clr_done;

    always_comb begin
        sum_a = {old_a[DATA_W-1], old_a} + {data_a_q[DATA_W-1], data_a_q};
        ovf_a = mode_a_q && (sum_a[DATA_W] != sum_a[DATA_W-1]);
        if (!mode_a_q)
            res_b_d = data_a_q;
        else if (ovf_a)
            res_b_d = sum_a[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            res_b_d = sum_a[DATA_W-1:0];
    end

    assign clr_done = (state_q == ST_CLEAR) && (clr_cnt_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_b_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_b_q <= va_q & ovf_a;
            if (clr_done)
                ovf_q <= 1'b0;
            else if (vb_q && ovf_b_q)
                ovf_q <= 1'b1;
        end
    end

    assign ovf_flag = ovf_q;
`else
    // Wrapping add: the carry out of the DATA_W-bit sum is simply dropped.
    assign res_b_d  = mode_a_q ? (old_a + data_a_q) : data_a_q;
    assign ovf_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            va_q     <= 1'b0;
            mode_a_q <= 1'b0;
            addr_a_q <= '0;
            data_a_q <= '0;
            vb_q     <= 1'b0;
            addr_b_q <= '0;
            res_b_q  <= '0;
        end else begin
            va_q <= accept;
            if (accept) begin
                mode_a_q <= acc_mode;
                addr_a_q <= acc_addr;
                data_a_q <= acc_data;
            end
            vb_q <= va_q;
            if (va_q) begin
                addr_b_q <= addr_a_q;
                res_b_q  <= res_b_d;
            end
        end
    end

    // The pipeline is empty during CLEAR, so the two write sources never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else if (state_q == ST_CLEAR) begin
            rf_q[clr_cnt_q] <= '0;
        end else if (vb_q) begin
            rf_q[addr_b_q] <= res_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rf_q[rd_addr];
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_psum_acc_spad.sv
// Scoreboard bench for psum_acc_spad: reference model applies accepted requests in
// order two edges after acceptance; a monitor checks every registered read.
module tb_psum_acc_spad;
    localparam int DW  = 24;
    localparam int DEP = 32;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          acc_valid = 1'b0;
    logic          acc_mode = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          clr_start = 1'b0;
    logic          acc_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          ovf_flag;

    always #5 clk = ~clk;

    psum_acc_spad #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_mode  (acc_mode),
        .acc_addr  (acc_addr),
        .acc_data  (acc_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .clr_start (clr_start),
        .busy      (busy),
        .ovf_flag  (ovf_flag)
    );

    typedef struct {
        int            due;
        bit            mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    op_t           pend[$];
    logic [DW-1:0] mem [DEP];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] last_rd = '0;
    bit            exp_rv = 1'b0;
    bit            exp_ovf = 1'b0;
    bit            mon_en = 1'b0;
    bit            clr_act = 1'b0;
    int            clr_c = 0;
    int            clr_end = 0;
    int            edge_n = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    bit            d_rst, d_v, d_m, d_rd, d_clr;
    logic [AW-1:0] d_a, d_ra;
    logic [DW-1:0] d_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] acc_ref(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                              output bit sat);
        longint s = longint'($signed(o)) + longint'($signed(d));
        sat = 1'b0;
`ifdef PSUM_SAT_EN
        if (s > 64'sd8388607) begin
            s = 64'sd8388607;
            sat = 1'b1;
        end else if (s < -64'sd8388608) begin
            s = -64'sd8388608;
            sat = 1'b1;
        end
`endif
        return s[DW-1:0];
    endfunction

    function automatic void apply_op(input op_t o);
        bit s = 1'b0;
        if (o.mode) mem[o.addr] = acc_ref(mem[o.addr], o.data, s);
        else        mem[o.addr] = o.data;
        if (s) exp_ovf = 1'b1;
    endfunction

    function automatic void zero_mem();
        foreach (mem[i]) mem[i] = '0;
    endfunction

    // One clock: drive inputs after the falling edge, update the model for the
    // coming rising edge, then wait for it.
    task automatic step();
        int e;
        int last;
        bit rdy, bsy;
        e = edge_n;
        rst = d_rst; acc_valid = d_v; acc_mode = d_m; acc_addr = d_a; acc_data = d_d;
        rd_en = d_rd; rd_addr = d_ra; clr_start = d_clr;
        #1;
        bsy = clr_act && (e > clr_c);
        rdy = d_rst && !bsy;
        chk("acc_ready", acc_ready, rdy);
        chk("busy", busy, bsy);
        if (d_rst) begin
            if (d_rd) exp_rd.push_back(mem[d_ra]);
            while (pend.size() > 0 && pend[0].due == e) apply_op(pend.pop_front());
            if (d_v && rdy) pend.push_back('{e + 2, d_m, d_a, d_d});
            if (d_clr && rdy) begin
                clr_act = 1'b1;
                clr_c   = e;
                last    = (pend.size() > 0) ? pend[$].due : e;
                clr_end = ((last > e) ? last : e) + 1 + DEP;
            end
        end else begin
            pend.delete();
            exp_rd.delete();
            zero_mem();
            exp_ovf = 1'b0;
            clr_act = 1'b0;
        end
        @(posedge clk);
        exp_rv = d_rst && d_rd;
        if (!d_rst) last_rd = '0;
        if (clr_act && e == clr_end) begin
            zero_mem();
            exp_ovf = 1'b0;
            clr_act = 1'b0;
        end
        edge_n++;
        @(negedge clk);
    endtask

    task automatic go(input bit v, input bit m, input logic [AW-1:0] a, input logic [DW-1:0] dd,
                      input bit re, input logic [AW-1:0] ra, input bit c);
        d_v = v; d_m = m; d_a = a; d_d = dd; d_rd = re; d_ra = ra; d_clr = c;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) go(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic read_all();
        for (int k = 0; k < DEP; k++) go(1'b0, 1'b0, '0, '0, 1'b1, AW'(k), 1'b0);
        idle(1);
    endtask

    task automatic run_clear_out(input bit poke);
        int guard = 0;
        while (clr_act && guard < 200) begin
            go(poke, 1'b0, AW'($urandom), DW'($urandom), 1'b0, '0, poke & $urandom_range(0, 1));
            guard++;
        end
        if (clr_act) begin
            n_cmp++;
            n_fail++;
            $display("FAIL clear_timeout: still clearing after %0d cycles, required done", guard);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_valid", rd_valid, exp_rv);
            if (rd_valid) begin
                if (exp_rd.size() > 0) begin
                    last_rd = exp_rd.pop_front();
                    chk("rd_data", rd_data, last_rd);
                end
            end else begin
                chk("rd_hold", rd_data, last_rd);
            end
            chk("ovf_flag", ovf_flag, exp_ovf);
        end
    end

    initial begin
        d_rst = 1'b0; d_v = 1'b0; d_m = 1'b0; d_rd = 1'b0; d_clr = 1'b0;
        d_a = '0; d_ra = '0; d_d = '0;
        zero_mem();
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        idle(1);
        d_rst = 1'b1;

        read_all();

        go(1'b1, 1'b0, 5'd5, 24'h000123, 1'b0, '0, 1'b0);
        idle(2);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 1'b0);
        idle(1);

        for (int k = 1; k <= 4; k++) go(1'b1, 1'b1, 5'd7, DW'(k), 1'b0, '0, 1'b0);
        idle(2);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0);

        for (int k = 0; k < 6; k++) go(1'b1, 1'b1, (k % 2) ? 5'd4 : 5'd3, 24'd5, 1'b0, '0, 1'b0);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 1'b0);
        idle(1);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 1'b0);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 1'b0);

        for (int k = 0; k < DEP; k++) go(1'b1, 1'b0, AW'(k), DW'($urandom) | 24'h1, 1'b0, '0, 1'b0);
        idle(2);
        go(1'b1, 1'b1, 5'd9, 24'h000040, 1'b0, '0, 1'b1);
        run_clear_out(1'b1);
        read_all();

        go(1'b1, 1'b0, 5'd2, 24'h7FFFFF, 1'b0, '0, 1'b0);
        go(1'b1, 1'b1, 5'd2, 24'h000001, 1'b0, '0, 1'b0);
        go(1'b1, 1'b0, 5'd6, 24'h800000, 1'b0, '0, 1'b0);
        go(1'b1, 1'b1, 5'd6, 24'hFFFFFF, 1'b0, '0, 1'b0);
        go(1'b1, 1'b0, 5'd8, 24'h7FFFFF, 1'b0, '0, 1'b0);
        idle(2);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd2, 1'b0);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd6, 1'b0);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd8, 1'b0);
        go(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        run_clear_out(1'b0);
        go(1'b0, 1'b0, '0, '0, 1'b1, 5'd2, 1'b0);

        for (int k = 0; k < 600; k++) begin
            bit c;
            c = ($urandom_range(0, 149) == 0);
            go($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
               DW'($urandom), !clr_act && $urandom_range(0, 1), AW'($urandom_range(0, 7)), c);
        end
        run_clear_out(1'b0);
        read_all();

        for (int k = 0; k < 8; k++) go(1'b1, 1'b0, AW'(k), DW'($urandom) | 24'h1, 1'b0, '0, 1'b0);
        go(1'b1, 1'b1, 5'd1, 24'd5, 1'b0, '0, 1'b0);
        go(1'b1, 1'b1, 5'd1, 24'd7, 1'b0, '0, 1'b0);
        d_rst = 1'b0;
        go(1'b1, 1'b1, 5'd1, 24'd9, 1'b1, 5'd1, 1'b0);
        d_rst = 1'b1;
        read_all();

        for (int k = 0; k < DEP; k++) go(1'b1, 1'b0, AW'(k), DW'($urandom) | 24'h1, 1'b0, '0, 1'b0);
        go(1'b1, 1'b1, 5'd3, 24'h7FFFFF, 1'b0, '0, 1'b1);
        for (int k = 0; k < 12; k++) go(1'b1, 1'b0, AW'(k), 24'h1, 1'b0, '0, 1'b0);
        d_rst = 1'b0;
        go(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 1'b0);
        d_rst = 1'b1;
        read_all();

        idle(3);
        chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
